// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU and FIFO-buffered long-latency writebacks onto the RF write port, with a busy scoreboard
//   Ports: clk/rst (async, active-high); alu_valid/alu_ready/alu_addr/alu_data (priority source);
//   lsu_valid/lsu_ready/lsu_addr/lsu_data (buffered source); iss_valid/iss_addr (mark pending);
//   rf_we/rf_waddr/rf_wdata (registered RF write port); busy_vec (pending long-latency writes).
//   Optional RF_WB_BYPASS_EN: an LSU write into an empty FIFO that the ALU does not beat skips the FIFO.
module rf_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_addr,
   input  logic [31:0] alu_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_addr,
   input  logic [31:0] lsu_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_addr,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] busy_vec
);
   logic [36:0]   mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic [AW:0]   cnt;
   logic          full, empty, alu_go, lsu_go, pop, byp, push, win, lsu_win;
   logic [4:0]    w_addr;
   logic [31:0]   w_data, clr_mask, set_mask;
   assign full      = cnt == (AW+1)'(DEPTH);
   assign empty     = cnt == '0;
   assign alu_ready = ~full;
   assign lsu_ready = ~full;
   assign alu_go    = alu_valid & ~full;
   assign lsu_go    = lsu_valid & ~full;
   // a full FIFO beats the ALU so the long-latency path cannot starve
   assign pop       = full | (~alu_go & ~empty);
`ifdef RF_WB_BYPASS_EN
   assign byp       = lsu_go & empty & ~alu_go;
`else
   assign byp       = 1'b0;
`endif
   assign push      = lsu_go & ~byp;
   assign lsu_win   = pop | byp;
   assign win       = alu_go | lsu_win;
   always_comb begin
      w_addr = alu_go ? alu_addr : pop ? mem[rd][36:32] : lsu_addr;
      w_data = alu_go ? alu_data : pop ? mem[rd][31:0]  : lsu_data;
   end
   assign clr_mask = lsu_win ? (32'b1 << w_addr) : 32'b0;
   assign set_mask = iss_valid ? (32'b1 << iss_addr) : 32'b0;
   always_ff @(posedge clk)
      if (push) mem[wr] <= {lsu_addr, lsu_data};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd       <= '0;
         wr       <= '0;
         cnt      <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         busy_vec <= '0;
      end else begin
         if (push) wr <= wr + AW'(1);
         if (pop) rd <= rd + AW'(1);
         cnt   <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         // r0 winners are consumed but never written
         rf_we <= win & (w_addr != 5'd0);
         if (win) begin
            rf_waddr <= w_addr;
            rf_wdata <= w_data;
         end
         // set applied after clear so a same-cycle issue keeps the bit busy
         busy_vec <= ((busy_vec & ~clr_mask) | set_mask) & ~32'b1;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        alu_valid = 0, lsu_valid = 0, iss_valid = 0;
   logic [4:0]  alu_addr = 0, lsu_addr = 0, iss_addr = 0;
   logic [31:0] alu_data = 0, lsu_data = 0;
   logic        alu_ready, lsu_ready, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, busy_vec;
   rf_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
      .iss_valid(iss_valid), .iss_addr(iss_addr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
   );
   always #5 clk = ~clk;
   typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
   typedef struct { int c; logic [4:0] a; logic [31:0] d; } exp_t;
   ent_t        mq[$];
   exp_t        exp_q[$];
   logic [31:0] mbusy = 0;
   int          cyc = 0, n_cmp = 0, n_err = 0, full_seen = 0;
   bit          lsu_acc;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask
   task automatic step();
      bit full, alu_go, have, lw, byp;
      ent_t w;
      logic [31:0] nb;
      full = mq.size() == 4;
      if (full) full_seen++;
      check("alu_ready", alu_ready, !full);
      check("lsu_ready", lsu_ready, !full);
      alu_go = alu_valid && !full;
      lsu_acc = lsu_valid && !full;
      have = 0; lw = 0; byp = 0;
      if (full || (!alu_go && mq.size() > 0)) begin w = mq.pop_front(); have = 1; lw = 1; end
      else if (alu_go) begin w = '{alu_addr, alu_data}; have = 1; end
`ifdef RF_WB_BYPASS_EN
      else if (lsu_acc) begin w = '{lsu_addr, lsu_data}; have = 1; lw = 1; byp = 1; end
`endif
      if (lsu_acc && !byp) mq.push_back('{lsu_addr, lsu_data});
      if (have && w.a != 0) exp_q.push_back('{cyc + 1, w.a, w.d});
      nb = mbusy;
      if (have && lw) nb[w.a] = 1'b0;
      if (iss_valid) nb[iss_addr] = 1'b1;
      nb[0] = 1'b0;
      @(posedge clk);
      cyc++;
      mbusy = nb;
      @(negedge clk);
      check("rf_we", rf_we, exp_q.size() > 0 && exp_q[0].c == cyc);
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
         exp_t e = exp_q.pop_front();
         check("rf_waddr", rf_waddr, e.a);
         check("rf_wdata", rf_wdata, e.d);
      end
      check("busy_vec", busy_vec, mbusy);
   endtask
   task automatic idle();
      alu_valid = 0; lsu_valid = 0; iss_valid = 0;
   endtask
   initial begin
      @(negedge clk);
      check("rst_we", rf_we, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_busy", busy_vec, 0);
      check("rst_lsu_ready", lsu_ready, 1);
      check("rst_alu_ready", alu_ready, 1);
      rst = 0;
      // ALU only
      alu_valid = 1; alu_addr = 5; alu_data = 32'hDEAD_BEEF;
      step();
      check("t1_waddr", rf_waddr, 5);
      idle(); step();
      check("t1_we_off", rf_we, 0);
      // priority ALU over LSU
      alu_valid = 1; alu_addr = 3; alu_data = 1;
      lsu_valid = 1; lsu_addr = 4; lsu_data = 2;
      step();
      idle(); step();
      check("t2_r4", rf_waddr, 4);
      step();
      // full/wrap with ALU held valid
      begin
         int k = 0;
         for (int i = 0; i < 40; i++) begin
            alu_valid = 1; alu_addr = 5'(20 + (i % 8)); alu_data = 32'hA000 + i;
            lsu_valid = k < 6; lsu_addr = 5'(8 + k); lsu_data = 32'hB000 + k;
            step();
            if (lsu_acc) k++;
         end
         check("t3_pushed", k, 6);
      end
      check("t3_full_seen", full_seen > 0, 1);
      idle();
      for (int i = 0; i < 6; i++) step();
      // register 0
      alu_valid = 1; alu_addr = 0; alu_data = 32'h1234;
      check("t4_alu_ready", alu_ready, 1);
      step();
      check("t4_alu_r0_we", rf_we, 0);
      alu_valid = 0; lsu_valid = 1; lsu_addr = 0; lsu_data = 32'h5678;
      step();
      idle(); step(); step();
      // scoreboard
      iss_valid = 1; iss_addr = 7;
      step();
      check("t5_busy_set", busy_vec[7], 1);
      iss_valid = 0; lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h77;
      step();
      idle(); iss_valid = 1; iss_addr = 7;
      step();
      check("t5_commit_we", rf_we, 1);
      check("t5_set_wins", busy_vec[7], 1);
      iss_valid = 0; lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h78;
      step();
      idle(); step();
      check("t5_cleared", busy_vec[7], 0);
      iss_valid = 1; iss_addr = 0;
      step();
      check("t5_r0_never_busy", busy_vec[0], 0);
      // reset mid-operation with 3 queued entries
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1; alu_addr = 5'(1 + i); alu_data = i;
         lsu_valid = 1; lsu_addr = 5'(16 + i); lsu_data = 32'hC000 + i;
         iss_valid = 1; iss_addr = 5'(16 + i);
         step();
      end
      idle();
      check("t6_queued", mq.size(), 3);
      #2 rst = 1;
      #1;
      check("t6_we", rf_we, 0);
      check("t6_waddr", rf_waddr, 0);
      check("t6_wdata", rf_wdata, 0);
      check("t6_busy", busy_vec, 0);
      check("t6_lsu_ready", lsu_ready, 1);
      #1 rst = 0;
      mq.delete(); exp_q.delete(); mbusy = 0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) step();
      check("t6_no_pending", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
